// File: rtl/wave_meter.sv
// wave_meter: bus-mapped peak / trough / period meter for an 8-bit sample stream.
// Define WAVE_METER_IRQ_EN to build the per-peak irq pulse and the CTRL.irq_mask bit.
module wave_meter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  in,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RISING, FALLING} state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        enable_q;
  logic        have_peak_q;
  logic        ready_q;
  logic [7:0]  prev_q;
  logic [7:0]  peak_q;
  logic [7:0]  trough_q;
  logic [15:0] peak_count_q;
  logic [31:0] period_q;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] rdata_q;
  logic        irq_mask_q;

  logic ctrl_wr;
  logic clear;
  logic rise;
  logic fall;
  logic peak_ev;
  logic trough_ev;

  assign ctrl_wr   = valid && wstrb[0] && (addr[3:2] == 2'd0);
  assign clear     = ctrl_wr && wdata[1];
  assign rise      = in > prev_q;
  assign fall      = in < prev_q;
  // A clear in the same cycle wins: the event is dropped entirely.
  assign peak_ev   = enable_q && !clear && (state_q == RISING) && fall;
  assign trough_ev = enable_q && !clear && (state_q == FALLING) && rise;

  always_comb begin
    state_d = state_q;
    if (clear || !enable_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise)      state_d = RISING;
          else if (fall) state_d = FALLING;
        end
        RISING:  if (fall) state_d = FALLING;
        FALLING: if (rise) state_d = RISING;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear || !enable_q || peak_ev) pcnt_d = 32'd0;
    else if (pcnt_q != CNT_MAX)        pcnt_d = pcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      have_peak_q  <= 1'b0;
      ready_q      <= 1'b0;
      prev_q       <= 8'd0;
      peak_q       <= 8'd0;
      trough_q     <= 8'd0;
      peak_count_q <= 16'd0;
      period_q     <= 32'd0;
      pcnt_q       <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      ready_q <= valid;
      prev_q  <= in;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      if (ctrl_wr) enable_q <= wdata[0];

      case (addr[3:2])
        2'd0:    rdata_q <= {29'd0, irq_mask_q, 1'b0, enable_q};
        2'd1:    rdata_q <= {16'h0, trough_q, peak_q};
        2'd2:    rdata_q <= period_q;
        default: rdata_q <= {15'h0, state_q == FALLING, peak_count_q};
      endcase

      if (clear) begin
        peak_q       <= 8'd0;
        trough_q     <= 8'd0;
        period_q     <= 32'd0;
        peak_count_q <= 16'd0;
        have_peak_q  <= 1'b0;
      end else begin
        if (peak_ev) begin
          peak_q       <= prev_q;
          peak_count_q <= peak_count_q + 16'd1;
          have_peak_q  <= 1'b1;
          // The first peak after clear only arms the period measurement.
          if (have_peak_q) period_q <= (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + 32'd1;
        end
        if (trough_ev) trough_q <= prev_q;
      end
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

`ifdef WAVE_METER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_mask_q <= wdata[2];
      irq_q <= peak_ev && irq_mask_q;
    end
  end

  assign irq = irq_q;

  logic unused_bus;
  assign unused_bus = ^{addr[31:4], addr[1:0], wstrb[3:1], wdata[31:3]};
`else
  assign irq_mask_q = 1'b0;
  assign irq        = 1'b0;

  logic unused_bus;
  assign unused_bus = ^{addr[31:4], addr[1:0], wstrb[3:1], wdata[31:2]};
`endif

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter: bus reads after reset, ramp, clear-vs-peak,
// periodic triangle, long plateau and reset mid-measurement.
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  in;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_hi = 0;
  int irq_rise = 0;
  logic irq_last = 1'b0;

`ifdef WAVE_METER_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  always #5 clk = ~clk;

  wave_meter dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .wstrb  (wstrb),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .in     (in),
    .irq    (irq)
  );

  // Counts high cycles and rising edges so pulse width can be checked.
  always @(negedge clk) begin
    if (irq === 1'b1) irq_hi++;
    if (irq === 1'b1 && irq_last !== 1'b1) irq_rise++;
    irq_last = irq;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1;
    wstrb = 4'hF;
    addr  = a;
    wdata = d;
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'h0;
    wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
    valid = 1'b1;
    wstrb = 4'h0;
    addr  = a;
    @(negedge clk);
    check_val(tag, rdata, exp);
    valid = 1'b0;
  endtask

  task automatic sample(input logic [7:0] v);
    in = v;
    @(negedge clk);
  endtask

  logic [7:0] ramp [10];

  initial begin
    ramp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd2};
    resetn = 1'b0;
    valid  = 1'b0;
    wstrb  = 4'h0;
    addr   = 32'd0;
    wdata  = 32'd0;
    in     = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state and bus handshake
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(32'(a * 4), $sformatf("rst_reg%0d", a), 32'd0);
      check_val($sformatf("ready_hi%0d", a), {31'd0, ready}, 32'd1);
    end
    @(negedge clk);
    check_val("ready_lo", {31'd0, ready}, 32'd0);

    // Ramp up to 5, down to 1, back to 2
    bus_write(32'h0, 32'h5);
    bus_read(32'h0, "ctrl_rd", 32'(IRQ_ON ? 5 : 1));
    for (int i = 0; i < 10; i++) sample(ramp[i]);
    bus_read(32'h4, "ramp_pk_tr", 32'h0000_0105);
    bus_read(32'h8, "ramp_period", 32'd0);
    bus_read(32'hC, "ramp_cnt_dir", 32'h0000_0001);
    check_val("ramp_irq", irq_rise, 32'(IRQ_ON * 1));

    // Clear in the same cycle as a peak event (RISING at 2, next sample 1)
    in = 8'd1;
    bus_write(32'h0, 32'h3);
    bus_read(32'h0, "clr_ctrl", 32'h1);
    bus_read(32'h4, "clr_pk_tr", 32'd0);
    bus_read(32'h8, "clr_period", 32'd0);
    bus_read(32'hC, "clr_cnt", 32'd0);
    sample(8'd0);
    bus_read(32'hC, "clr_idle_fall", 32'h0001_0000);
    bus_read(32'h4, "clr_no_event", 32'd0);
    check_val("clr_irq", irq_rise, 32'(IRQ_ON * 1));

    // Triangle: peak at 10 every 20 cycles, three peaks
    bus_write(32'h0, 32'h5);
    for (int k = 0; k < 3; k++) begin
      for (int v = 1; v <= 10; v++) sample(8'(v));
      for (int v = 9; v >= 0; v--) sample(8'(v));
    end
    bus_read(32'h4, "tri_pk_tr", 32'h0000_000A);
    bus_read(32'h8, "tri_period", 32'd20);
    bus_read(32'hC, "tri_cnt_dir", 32'h0001_0003);
    check_val("tri_irq", irq_rise, 32'(IRQ_ON * 4));

    // Plateau at 0x80 in RISING, then a peak measures the long period
    bus_write(32'h0, 32'h7);
    sample(8'd1);
    sample(8'd0);
    sample(8'h80);
    repeat (1000) sample(8'h80);
    bus_read(32'hC, "hold_rising", 32'h0000_0001);
    bus_read(32'h4, "hold_no_peak", 32'h0000_0001);
    bus_read(32'h8, "hold_period0", 32'd0);
    sample(8'h7F);
    bus_read(32'h8, "hold_period", 32'd1005);
    bus_read(32'h4, "hold_pk_tr", 32'h0000_0080);

    // Build up to 7 peaks, then reset mid-FALLING with a bus write and sample event
    for (int k = 0; k < 5; k++) begin
      sample(8'h80);
      sample(8'h7F);
    end
    bus_read(32'hC, "pre_rst_cnt", 32'h0001_0007);
    @(negedge clk);
    check_val("irq_pulses", irq_rise, 32'(IRQ_ON * 11));
    check_val("irq_width", irq_hi, 32'(IRQ_ON * 11));
    resetn = 1'b0;
    in     = 8'h80;
    valid  = 1'b1;
    wstrb  = 4'hF;
    addr   = 32'h0;
    wdata  = 32'h5;
    @(negedge clk);
    check_val("mid_rst_ready", {31'd0, ready}, 32'd0);
    check_val("mid_rst_rdata", rdata, 32'd0);
    check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    valid  = 1'b0;
    wstrb  = 4'h0;
    wdata  = 32'd0;
    for (int a = 0; a < 4; a++) bus_read(32'(a * 4), $sformatf("post_rst_reg%0d", a), 32'd0);
    @(negedge clk);
    check_val("post_rst_irq", irq_rise, 32'(IRQ_ON * 11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
